if_id_hazard_ctrl: RTL and testbench
====================================

IF_ID_HAZARD_CTRL -- requirements
Module: if_id_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: cycles the IF/ID register is flushed after a taken branch; legal range 1..15.
REQ-002 Parameter CNT_W, default 8: width of each statistics counter.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low; sampled on rising edge of clock.
REQ-005 ifid_rs  in  5  rs field of the instruction held in IF/ID.
REQ-006 ifid_rt  in  5  rt field of the instruction held in IF/ID.
REQ-007 ifid_uses_rt  in  1  1 = the IF/ID instruction reads rt as a source.
REQ-008 idex_memread  in  1  1 = the ID/EX instruction is a load.
REQ-009 idex_rt  in  5  load destination register in ID/EX.
REQ-010 branch_taken  in  1  taken branch/jump resolved this cycle.
REQ-011 imem_ready  in  1  instruction memory output valid this cycle.
REQ-012 pc_write  out  1  PC update enable.
REQ-013 ifid_write  out  1  IF/ID load enable.
REQ-014 ifid_flush  out  1  IF/ID clear; overrides ifid_write.
REQ-015 idex_bubble  out  1  insert NOP into ID/EX.
REQ-016 state  out  2  current FSM state encoding.
REQ-017 stall_count  out  CNT_W  cycles with ifid_write=0.
REQ-018 flush_count  out  CNT_W  cycles with ifid_flush=1.

Function
REQ-019 load_use SHALL equal idex_memread AND idex_rt!=0 AND (idex_rt==ifid_rs OR (ifid_uses_rt AND idex_rt==ifid_rt)).
REQ-020 FSM states SHALL be RUN=00, LDSTALL=01, FLUSH=10, IWAIT=11; state output reflects the registered state.
REQ-021 Control outputs SHALL be combinational from state, flush counter and inputs (zero-cycle latency); state and counters are registered.
REQ-022 Output vector "advance" = pc_write 1, ifid_write 1, ifid_flush 0, idex_bubble 0; "stall" = pc_write 0, ifid_write 0, ifid_flush 0, idex_bubble 1; "redirect" = pc_write 1, ifid_write 1, ifid_flush 1, idex_bubble 1.
REQ-023 In RUN and IWAIT, priority SHALL be branch_taken > load_use > !imem_ready > advance.
REQ-024 RUN/IWAIT with branch_taken: drive redirect; next state FLUSH with flush counter = FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES==1.
REQ-025 RUN/IWAIT with load_use (no branch): drive stall; next state LDSTALL.
REQ-026 RUN/IWAIT with !imem_ready (no branch, no load_use): drive stall; next state IWAIT.
REQ-027 RUN/IWAIT otherwise: drive advance; next state RUN.
REQ-028 LDSTALL: branch_taken handled as REQ-024; load_use ignored; !imem_ready drives stall, next IWAIT; otherwise advance, next RUN.
REQ-029 FLUSH: drive ifid_write 1, ifid_flush 1, idex_bubble 1, pc_write=imem_ready; branch_taken and load_use ignored.
REQ-030 FLUSH: counter decrements only on cycles with imem_ready=1; when counter==1 and imem_ready=1, next state RUN; else remain.
REQ-031 stall_count SHALL increment when ifid_write==0 and flush_count when ifid_flush==1, both saturating at 2^CNT_W-1, never wrapping.
REQ-032 Simultaneous branch_taken and load_use in RUN SHALL count as a flush cycle only, not a stall.

Reset
REQ-033 reset==0 at a rising edge SHALL set state=RUN, flush counter=0, stall_count=0, flush_count=0.
REQ-034 While reset==0, outputs SHALL be pc_write 0, ifid_write 0, ifid_flush 1, idex_bubble 1, regardless of state; counters do not count these cycles.
REQ-035 Reset asserted mid-FLUSH or mid-IWAIT SHALL abandon the sequence; first cycle after release is RUN with no residual flush.

Verification
REQ-036 Load-use: idex_memread=1, idex_rt=8, ifid_rs=8, imem_ready=1 -> one cycle stall, state 01, next cycle advance, state 00, stall_count +1.
REQ-037 R0 exemption: idex_memread=1, idex_rt=0, ifid_rs=0 -> advance, no stall, stall_count unchanged.
REQ-038 Branch, FLUSH_CYCLES=2: branch_taken=1 one cycle -> redirect, then one FLUSH cycle (state 10), then RUN; flush_count +2.
REQ-039 Imem wait in FLUSH: branch then imem_ready=0 for 3 cycles -> FLUSH held with pc_write 0 for 3 cycles, exits after next ready cycle.
REQ-040 Priority/saturation: branch_taken with load_use -> redirect, stall_count unchanged; hold imem_ready=0 for 300 cycles, CNT_W=8 -> stall_count stops at 255.
REQ-041 Reset mid-FLUSH: assert reset=0 for 1 cycle in FLUSH -> state 00, counters 0, next cycle advance.

Source files
------------

// File: rtl/if_id_hazard_ctrl_if.sv
// rtl/if_id_hazard_ctrl_if.sv - IF/ID hazard controller signal bundle
// The pipeline side is the master; the hazard controller is the slave.
interface if_id_hazard_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic             branch_taken;
  logic             imem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
           branch_taken, imem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
           state, stall_count, flush_count
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
           branch_taken, imem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
           state, stall_count, flush_count
  );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// rtl/if_id_hazard_ctrl.sv - IF/ID hazard control: load-use stall, branch flush, imem wait
// Control outputs are combinational from the registered state; counters saturate.
module if_id_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  if_id_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    FLUSH   = 2'b10,
    IWAIT   = 2'b11
  } state_t;

  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;

  // Register $0 never carries a real dependency.
  assign load_use = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                    ((hz.idex_rt == hz.ifid_rs) ||
                     (hz.ifid_uses_rt && (hz.idex_rt == hz.ifid_rt)));

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    case (state_q)
      RUN, IWAIT, LDSTALL: begin
        if (hz.branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES == 1) begin
            state_d = RUN;
            fcnt_d  = 4'd0;
          end else begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_INIT;
          end
        end else if (load_use && (state_q != LDSTALL)) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = LDSTALL;
        end else if (!hz.imem_ready) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = IWAIT;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        pc_write    = hz.imem_ready;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (hz.imem_ready) begin
          if (fcnt_q <= 4'd1) begin
            state_d = RUN;
            fcnt_d  = 4'd0;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    // Reset forces a safe bubble/flush regardless of the held state.
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (!ifid_write && (stall_cnt_q != CNT_MAX))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_flush && (flush_cnt_q != CNT_MAX))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.state       = state_q;
  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// tb/tb_if_id_hazard_ctrl.sv - directed table and sequence checks for if_id_hazard_ctrl
module tb_if_id_hazard_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  if_id_hazard_ctrl_if #(.CNT_W(8)) hz ();

  if_id_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ctl = {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] ADV  = 4'b1100;
  localparam logic [3:0] STL  = 4'b0001;
  localparam logic [3:0] RDR  = 4'b1111;
  localparam logic [3:0] FWT  = 4'b0111;
  localparam logic [3:0] RSTV = 4'b0011;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] xrt;
    logic       br;
    logic       rdy;
    logic [3:0] exp_ctl;
    logic [1:0] exp_st;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic [4:0] rs, rt, input logic ur, mr,
                              input logic [4:0] xrt, input logic br, rdy,
                              input logic [3:0] ctl, input logic [1:0] st);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = ur; v.memread = mr; v.xrt = xrt;
    v.br = br; v.rdy = rdy; v.exp_ctl = ctl; v.exp_st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ctl();
    return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble};
  endfunction

  task automatic drive(input logic [4:0] rs, rt, input logic ur, mr,
                       input logic [4:0] xrt, input logic br, rdy);
    hz.ifid_rs      = rs;
    hz.ifid_rt      = rt;
    hz.ifid_uses_rt = ur;
    hz.idex_memread = mr;
    hz.idex_rt      = xrt;
    hz.branch_taken = br;
    hz.imem_ready   = rdy;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

    //            rs    rt    ur    mr    xrt   br    rdy   ctl  state
    tbl[0]  = mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, ADV, 2'b00);
    tbl[1]  = mk(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, STL, 2'b00);
    tbl[2]  = mk(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, ADV, 2'b01);
    tbl[3]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, ADV, 2'b00);
    tbl[4]  = mk(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, ADV, 2'b00);
    tbl[5]  = mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, STL, 2'b00);
    tbl[6]  = mk(5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, STL, 2'b01);
    tbl[7]  = mk(5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, STL, 2'b11);
    tbl[8]  = mk(5'd5, 5'd4, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, STL, 2'b11);
    tbl[9]  = mk(5'd5, 5'd4, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, RDR, 2'b01);
    tbl[10] = mk(5'd5, 5'd4, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, FWT, 2'b10);
    tbl[11] = mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, RDR, 2'b10);
    tbl[12] = mk(5'd4, 5'd2, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, ADV, 2'b00);
    tbl[13] = mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, STL, 2'b00);
    tbl[14] = mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, RDR, 2'b11);
    tbl[15] = mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, RDR, 2'b10);
    tbl[16] = mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, ADV, 2'b00);

    // Outputs while held in reset, then the cleared state.
    @(negedge clock);
    #1;
    chk("reset_ctl", 32'(ctl()), 32'(RSTV));
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("reset_state", 32'(hz.state), 32'd0);
    chk("reset_stall_cnt", 32'(hz.stall_count), 32'd0);
    chk("reset_flush_cnt", 32'(hz.flush_count), 32'd0);

    for (int i = 0; i < 17; i++) begin
      if (i != 0) @(negedge clock);
      drive(tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].memread,
            tbl[i].xrt, tbl[i].br, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(tbl[i].exp_ctl));
      chk($sformatf("vec%0d_state", i), 32'(hz.state), 32'(tbl[i].exp_st));
    end
    @(negedge clock);
    #1;
    chk("table_stall_cnt", 32'(hz.stall_count), 32'd6);
    chk("table_flush_cnt", 32'(hz.flush_count), 32'd5);

    // Branch followed by three instruction-memory wait cycles inside FLUSH.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    #1;
    chk("iw_redirect", 32'(ctl()), 32'(RDR));
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      chk($sformatf("iw_hold%0d_ctl", k), 32'(ctl()), 32'(FWT));
      chk($sformatf("iw_hold%0d_state", k), 32'(hz.state), 32'd2);
    end
    @(negedge clock);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("iw_last_ctl", 32'(ctl()), 32'(RDR));
    chk("iw_last_state", 32'(hz.state), 32'd2);
    @(negedge clock);
    #1;
    chk("iw_exit_state", 32'(hz.state), 32'd0);
    chk("iw_exit_ctl", 32'(ctl()), 32'(ADV));
    chk("iw_flush_cnt", 32'(hz.flush_count), 32'd5);
    chk("iw_stall_cnt", 32'(hz.stall_count), 32'd0);

    // Branch wins over load-use; then stall counter saturation.
    do_reset();
    drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);
    #1;
    chk("pri_ctl", 32'(ctl()), 32'(RDR));
    @(negedge clock);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("pri_stall_cnt", 32'(hz.stall_count), 32'd0);
    chk("pri_state", 32'(hz.state), 32'd2);
    @(negedge clock);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (300) @(negedge clock);
    #1;
    chk("sat_stall_cnt", 32'(hz.stall_count), 32'd255);
    chk("sat_flush_cnt", 32'(hz.flush_count), 32'd2);
    chk("sat_state", 32'(hz.state), 32'd3);

    // Reset pulse in the middle of a flush.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    @(negedge clock);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("mid_flush_state", 32'(hz.state), 32'd2);
    reset = 1'b0;
    #1;
    chk("mid_reset_ctl", 32'(ctl()), 32'(RSTV));
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("post_reset_state", 32'(hz.state), 32'd0);
    chk("post_reset_stall", 32'(hz.stall_count), 32'd0);
    chk("post_reset_flush", 32'(hz.flush_count), 32'd0);
    chk("post_reset_ctl", 32'(ctl()), 32'(ADV));
    @(negedge clock);
    #1;
    chk("post_reset_run", 32'(hz.state), 32'd0);
    chk("post_reset_noflush", 32'(hz.flush_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
